result_bcd_display: RTL and testbench
=====================================

Name: result_bcd_display

Overview:
- Downstream stage of the calculator ALU: consumes the 15-bit registered result and converts it to five BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Registers 7-segment patterns for each digit and a sign digit.
- Drives the board's result display; the operand displays reuse its segment encoder.

Parameters:
- BLANK_LZ, 1, 1 = leading-zero digits drive blank segments; digit0 never blanks.
- WIDTH, 15, result width; fixed at 15 for this design, so NDIG = 5.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- res_in  in  15  result word from the ALU.
- res_valid  in  1  request conversion of res_in; sampled only in IDLE.
- signed_mode  in  1  1 = treat res_in as two's complement (subtract results); sampled with res_in.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new outputs are valid.
- neg  out  1  registered sign of the last converted value.
- bcd  out  20  {d4,d3,d2,d1,d0}, 4 bits each, d0 = units.
- seg0..seg4  out  7 each  active-high segments {g,f,e,d,c,b,a} for d0..d4.
- seg_sign  out  7  0x40 (minus) when neg = 1, else 0x00.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; busy = 0, done = 0, neg = 0, bcd = 0.
  - seg0 = 0x3F; seg1..seg4 = 0x00 when BLANK_LZ = 1, else 0x3F; seg_sign = 0x00.
  - Reset mid-conversion aborts the conversion; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - res_valid = 1 at edge E0 captures the magnitude into a 15-bit shift register.
  - Magnitude: if signed_mode & res_in[14], it is (~res_in + 1) and neg_next = 1; otherwise it is res_in and neg_next = 0.
  - The 20-bit BCD scratch register clears; counter = 0; state goes to SHIFT; busy = 1.
- SHIFT, one edge per bit, edges E1..E15:
  - Each BCD nibble >= 5 gets +3 (combinational, computed before the shift).
  - Then {scratch, shreg} shifts left 1; counter increments.
  - After the 15th shift (counter = 14 at the edge), state goes to DONE.
- DONE, edge E16:
  - bcd, neg, seg0..seg4 and seg_sign load from the scratch register and neg_next.
  - done = 1 for exactly the cycle following E16; busy = 0; state goes to IDLE.
- Latency: outputs and the done pulse appear 16 clocks after the capture edge. Earliest next capture is E17.
- res_valid while busy = 1 is ignored; it is not queued. Holding res_valid high restarts a conversion every 17 cycles.
- Outputs hold their previous values throughout a conversion; there are no partial updates.
- Segment codes:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66.
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Blank = 00. Nibbles above 9 cannot occur; encode them as 00.
- Leading-zero blanking (BLANK_LZ = 1): digit k blanks if it and every digit above it are 0, for k >= 1.
- Edge values:
  - Signed minimum 0x4000 gives magnitude 16384 with neg = 1.
  - Unsigned maximum 0x7FFF gives 32767.

Test Plan:
- Reset release, then res_in = 12345, signed_mode = 0, pulse res_valid -> busy for 16 cycles; then done pulses once; bcd = 0x12345; seg4..seg0 = 06,5B,4F,66,6D; neg = 0; seg_sign = 00.
- res_in = 0 -> bcd = 0x00000; seg0 = 3F; seg1..seg4 = 00 (BLANK_LZ = 1); with BLANK_LZ = 0 all are 3F.
- res_in = 0x7FFE, signed_mode = 1 -> neg = 1, bcd = 0x00002, seg0 = 5B, seg_sign = 40; same input with signed_mode = 0 -> bcd = 0x32766, neg = 0.
- res_in = 0x4000, signed_mode = 1 -> bcd = 0x16384, neg = 1; res_in = 0x7FFF, signed_mode = 0 -> bcd = 0x32767.
- Start 100, pulse res_valid with res_in = 999 at cycle 5 while busy -> ignored; result stays 100 (seg2..seg0 = 06,3F,3F; seg3, seg4 = 00); exactly one done pulse.
- Convert 42, then start 777 and drop rst at cycle 8 -> outputs return to reset values immediately; no done pulse; after release, 55 converts correctly with latency 16.

Source files
------------

// File: rtl/result_bcd_display.sv
// result_bcd_display: turns the ALU result into five BCD digits with a serial
// double-dabble engine (one result bit per clock). It then registers the
// 7-segment patterns for every digit and for the sign digit.
// Outputs change only when a conversion finishes, so the display never shows
// a partially converted value.
module result_bcd_display #(
    parameter bit BLANK_LZ = 1'b1,
    parameter int WIDTH    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] res_in,
    input  logic             res_valid,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [19:0]      bcd,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3,
    output logic [6:0]       seg4,
    output logic [6:0]       seg_sign,
    output logic [1:0]       state_dbg
);

    localparam int NDIG = 5;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    // Digits 1..4 show blank out of reset when leading zeros are suppressed.
    localparam logic [6:0] SEG_HI_RST = BLANK_LZ ? 7'h00 : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    shreg_q;
    logic [4*NDIG-1:0]   scratch_q;
    logic [3:0]          cnt_q;
    logic                neg_next_q;

    logic [WIDTH-1:0]    mag_d;
    logic                neg_d;
    logic [4*NDIG-1:0]   scratch_adj;
    logic [4*NDIG-1:0]   scratch_d;
    logic [WIDTH-1:0]    shreg_d;
    logic [3:0]          nib;
    logic [NDIG-1:0]     zero_dig;
    logic [NDIG-1:0]     blank_dig;
    logic [6:0]          seg0_d, seg1_d, seg2_d, seg3_d, seg4_d;

    assign state_dbg = state_q;

    // Active-high {g,f,e,d,c,b,a} pattern; values above 9 never occur and stay dark.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Magnitude and sign of the incoming result (two's complement only in signed mode).
    always_comb begin
        mag_d = res_in;
        neg_d = 1'b0;
        if (signed_mode && res_in[WIDTH-1]) begin
            mag_d = ~res_in + WIDTH'(1);
            neg_d = 1'b1;
        end
    end

    // Add-3 correction of every nibble >= 5, then the one-bit left shift of {scratch, shreg}.
    always_comb begin
        scratch_adj = '0;
        nib         = '0;
        for (int i = 0; i < NDIG; i++) begin
            nib = scratch_q[4*i +: 4];
            scratch_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        scratch_d = {scratch_adj[4*NDIG-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
    end

    // Leading-zero blanking: a digit blanks when it and all digits above it are zero.
    always_comb begin
        zero_dig  = '0;
        blank_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            zero_dig[i] = (scratch_q[4*i +: 4] == 4'd0);
        end
        blank_dig[4] = BLANK_LZ && zero_dig[4];
        blank_dig[3] = blank_dig[4] && zero_dig[3];
        blank_dig[2] = blank_dig[3] && zero_dig[2];
        blank_dig[1] = blank_dig[2] && zero_dig[1];
        blank_dig[0] = 1'b0;
        seg0_d = seg7(scratch_q[3:0]);
        seg1_d = blank_dig[1] ? 7'h00 : seg7(scratch_q[7:4]);
        seg2_d = blank_dig[2] ? 7'h00 : seg7(scratch_q[11:8]);
        seg3_d = blank_dig[3] ? 7'h00 : seg7(scratch_q[15:12]);
        seg4_d = blank_dig[4] ? 7'h00 : seg7(scratch_q[19:16]);
    end

    // Control FSM: capture in IDLE, shift one bit per clock, publish all outputs in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            neg_next_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            neg        <= 1'b0;
            bcd        <= '0;
            seg0       <= SEG_ZERO;
            seg1       <= SEG_HI_RST;
            seg2       <= SEG_HI_RST;
            seg3       <= SEG_HI_RST;
            seg4       <= SEG_HI_RST;
            seg_sign   <= 7'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (res_valid) begin
                        shreg_q    <= mag_d;
                        neg_next_q <= neg_d;
                        scratch_q  <= '0;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_d;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'(WIDTH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= scratch_q;
                    neg      <= neg_next_q;
                    seg0     <= seg0_d;
                    seg1     <= seg1_d;
                    seg2     <= seg2_d;
                    seg3     <= seg3_d;
                    seg4     <= seg4_d;
                    seg_sign <= neg_next_q ? SEG_MINUS : 7'h00;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Bench for result_bcd_display: two instances (leading-zero blanking on/off)
// share stimulus; expected outputs come from a decimal-arithmetic model.
module tb_result_bcd_display;

    logic        clk;
    logic        rst;
    logic [14:0] res_in;
    logic        res_valid;
    logic        signed_mode;

    logic        busy_a, done_a, neg_a;
    logic [19:0] bcd_a;
    logic [6:0]  s0_a, s1_a, s2_a, s3_a, s4_a, sign_a;
    logic [1:0]  st_a;
    logic        busy_b, done_b, neg_b;
    logic [19:0] bcd_b;
    logic [6:0]  s0_b, s1_b, s2_b, s3_b, s4_b, sign_b;
    logic [1:0]  st_b;

    logic [62:0] obs_a, obs_b;
    assign obs_a = {bcd_a, neg_a, sign_a, s4_a, s3_a, s2_a, s1_a, s0_a};
    assign obs_b = {bcd_b, neg_b, sign_b, s4_b, s3_b, s2_b, s1_b, s0_b};

    int total = 0;
    int bad   = 0;
    logic [62:0] exp_q[$];

    result_bcd_display #(.BLANK_LZ(1'b1), .WIDTH(15)) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid),
        .signed_mode(signed_mode), .busy(busy_a), .done(done_a), .neg(neg_a),
        .bcd(bcd_a), .seg0(s0_a), .seg1(s1_a), .seg2(s2_a), .seg3(s3_a),
        .seg4(s4_a), .seg_sign(sign_a), .state_dbg(st_a)
    );

    result_bcd_display #(.BLANK_LZ(1'b0), .WIDTH(15)) dut_nb (
        .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid),
        .signed_mode(signed_mode), .busy(busy_b), .done(done_b), .neg(neg_b),
        .bcd(bcd_b), .seg0(s0_b), .seg1(s1_b), .seg2(s2_b), .seg3(s3_b),
        .seg4(s4_b), .seg_sign(sign_b), .state_dbg(st_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model -------------------------------------------------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h3F;  1: seg_of = 7'h06;  2: seg_of = 7'h5B;
            3: seg_of = 7'h4F;  4: seg_of = 7'h66;  5: seg_of = 7'h6D;
            6: seg_of = 7'h7D;  7: seg_of = 7'h07;  8: seg_of = 7'h7F;
            9: seg_of = 7'h6F;  default: seg_of = 7'h00;
        endcase
    endfunction

    // Expected {bcd, neg, seg_sign, seg4..seg0} for a converted value.
    function automatic logic [62:0] model(input int r, input bit sm, input bit blank);
        int mag, v;
        int d[5];
        logic [19:0] b;
        logic [6:0] sg[5];
        bit lead, ng;
        ng  = sm && (r >= 16384);
        mag = ng ? 32768 - r : r;
        v = mag;
        b = '0;
        for (int k = 0; k < 5; k++) begin
            d[k] = v % 10;
            v = v / 10;
            b[4*k +: 4] = 4'(d[k]);
        end
        lead = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            if (blank && lead && k > 0 && d[k] == 0) sg[k] = 7'h00;
            else begin
                lead = 1'b0;
                sg[k] = seg_of(d[k]);
            end
        end
        return {b, ng, (ng ? 7'h40 : 7'h00), sg[4], sg[3], sg[2], sg[1], sg[0]};
    endfunction

    // Driver tasks ----------------------------------------------------------
    // Present one request; returns #1 after the capture edge with res_valid low.
    task automatic drive_start(input int r, input bit sm);
        @(negedge clk);
        res_in      = 15'(r);
        signed_mode = sm;
        res_valid   = 1'b1;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    // Count clocks until done is seen (bounded at 40).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done_a !== 1'b1 && cyc < 40);
    endtask

    // Tests -----------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b0; res_in = '0; res_valid = 1'b0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_a !== model(0, 0, 1)) begin
            bad++; $display("FAIL reset_outputs_blank got=%h want=%h", obs_a, model(0, 0, 1));
        end
        total++;
        if (obs_b !== model(0, 0, 0)) begin
            bad++; $display("FAIL reset_outputs_noblank got=%h want=%h", obs_b, model(0, 0, 0));
        end
        total++;
        if ({busy_a, done_a} !== 2'b00) begin
            bad++; $display("FAIL reset_busy_done got=%b want=00", {busy_a, done_a});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int cyc, busy_err, dones;
        drive_start(12345, 0);
        cyc = 0; busy_err = 0;
        if (busy_a !== 1'b1) busy_err++;
        while (done_a !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_a !== 1'b1 && (busy_a !== 1'b1 || obs_a !== model(0, 0, 1))) busy_err++;
        end
        total++;
        if (cyc !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", cyc); end
        total++;
        if (busy_err !== 0) begin bad++; $display("FAIL basic_busy_hold got=%0d errs want=0", busy_err); end
        total++;
        if (bcd_a !== 20'h12345) begin bad++; $display("FAIL basic_bcd got=%h want=12345", bcd_a); end
        total++;
        if (obs_a !== model(12345, 0, 1)) begin
            bad++; $display("FAIL basic_outputs got=%h want=%h", obs_a, model(12345, 0, 1));
        end
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy_a); end
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL basic_done_width got=%0d extra want=0", dones); end
    endtask

    task automatic test_zero;
        int cyc;
        drive_start(0, 0);
        wait_done(cyc);
        total++;
        if (obs_a !== model(0, 0, 1) || s1_a !== 7'h00 || s0_a !== 7'h3F) begin
            bad++; $display("FAIL zero_blank got=%h want=%h", obs_a, model(0, 0, 1));
        end
        total++;
        if (obs_b !== model(0, 0, 0) || s4_b !== 7'h3F) begin
            bad++; $display("FAIL zero_noblank got=%h want=%h", obs_b, model(0, 0, 0));
        end
    endtask

    task automatic test_signed_edges;
        int cyc;
        int          r_t[4]   = '{32766, 32766, 16384, 32767};
        bit          sm_t[4]  = '{1, 0, 1, 0};
        logic [19:0] bcd_t[4] = '{20'h00002, 20'h32766, 20'h16384, 20'h32767};
        bit          neg_t[4] = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive_start(r_t[i], sm_t[i]);
            wait_done(cyc);
            total++;
            if (bcd_a !== bcd_t[i] || neg_a !== neg_t[i]) begin
                bad++; $display("FAIL edge%0d_bcd_neg got=%h/%b want=%h/%b", i, bcd_a, neg_a, bcd_t[i], neg_t[i]);
            end
            total++;
            if (obs_a !== model(r_t[i], sm_t[i], 1)) begin
                bad++; $display("FAIL edge%0d_outputs got=%h want=%h", i, obs_a, model(r_t[i], sm_t[i], 1));
            end
        end
    endtask

    task automatic test_ignore_busy;
        int dones;
        drive_start(100, 0);
        dones = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1) dones++;
            if (c == 5) begin res_in = 15'd999; res_valid = 1'b1; end
            if (c == 6) res_valid = 1'b0;
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        total++;
        if (obs_a !== model(100, 0, 1) || bcd_a !== 20'h00100) begin
            bad++; $display("FAIL ignore_result got=%h want=%h", obs_a, model(100, 0, 1));
        end
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%b want=0", busy_a); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        res_in = 15'd321; signed_mode = 1'b0; res_valid = 1'b1;
        @(posedge clk);
        #1;
        res_in = 15'd654;
        wait_done(cyc);
        total++;
        if (cyc !== 16 || obs_a !== model(321, 0, 1)) begin
            bad++; $display("FAIL b2b_first got=%0d/%h want=16/%h", cyc, obs_a, model(321, 0, 1));
        end
        wait_done(cyc);
        res_valid = 1'b0;
        total++;
        if (cyc !== 17 || obs_a !== model(654, 0, 1)) begin
            bad++; $display("FAIL b2b_second got=%0d/%h want=17/%h", cyc, obs_a, model(654, 0, 1));
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_stop got=%b want=0", busy_a); end
    endtask

    task automatic test_reset_mid;
        int cyc, dones;
        drive_start(42, 0);
        wait_done(cyc);
        total++;
        if (obs_a !== model(42, 0, 1)) begin
            bad++; $display("FAIL rstmid_first got=%h want=%h", obs_a, model(42, 0, 1));
        end
        drive_start(777, 0);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (obs_a !== model(0, 0, 1) || obs_b !== model(0, 0, 0) || {busy_a, done_a} !== 2'b00) begin
            bad++; $display("FAIL rstmid_async got=%h busy=%b want=%h busy=0", obs_a, busy_a, model(0, 0, 1));
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1 || busy_a === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
        drive_start(55, 0);
        wait_done(cyc);
        total++;
        if (cyc !== 16 || obs_a !== model(55, 0, 1)) begin
            bad++; $display("FAIL rstmid_after got=%0d/%h want=16/%h", cyc, obs_a, model(55, 0, 1));
        end
    endtask

    task automatic test_random;
        int cyc, r;
        bit sm;
        logic [62:0] exp_a, exp_b;
        for (int i = 0; i < 25; i++) begin
            r  = int'($urandom_range(0, 32767));
            sm = 1'($urandom_range(0, 1));
            exp_q.push_back(model(r, sm, 1));
            exp_q.push_back(model(r, sm, 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_start(r, sm);
            wait_done(cyc);
            exp_a = exp_q.pop_front();
            exp_b = exp_q.pop_front();
            total++;
            if (cyc !== 16 || obs_a !== exp_a || obs_b !== exp_b) begin
                bad++;
                $display("FAIL random%0d r=%0d sm=%0d lat=%0d got=%h/%h want=%h/%h",
                         i, r, sm, cyc, obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_signed_edges();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
